store_buffer: RTL and testbench

Posted-write buffer between the pipeline's MEM stage and `data_mem`. Stores from the CPU are queued and retired to `data_mem` one per cycle, only in cycles when no load needs the memory port. Loads are served from `data_mem` with youngest-match forwarding from the queue. A full queue stalls the pipeline.

---
 rtl/store_buffer.sv | 77 +++++++
 tb/tb_store_buffer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write queue between the MEM stage and data_mem, with youngest-match load forwarding.
//   clk, rst_n                         : clock and asynchronous active-low reset
//   StoreValid/StoreAddr/StoreData     : word store from the MEM stage
//   LoadValid/LoadAddr, LoadData       : word load request and its result (forwarded or from memory)
//   Stall                              : store not accepted this cycle
//   MemWriteEnable/MemAddress/MemWriteData, MemReadData : data_mem port
//   Count, Empty                       : occupancy
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int IDX_HI = 13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       StoreValid,
  input  logic [31:0]                StoreAddr,
  input  logic [31:0]                StoreData,
  input  logic                       LoadValid,
  input  logic [31:0]                LoadAddr,
  output logic [31:0]                LoadData,
  output logic                       Stall,
  output logic                       MemWriteEnable,
  output logic [31:0]                MemAddress,
  output logic [31:0]                MemWriteData,
  input  logic [31:0]                MemReadData,
  output logic [$clog2(DEPTH):0]     Count,
  output logic                       Empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;
  logic          w_drain, w_accept, w_hit;
  logic [31:0]   w_fwd;
  // Loads own the memory port; the queue drains only in load-free cycles.
  assign w_drain        = !LoadValid && r_count != '0;
  // A full queue can still accept when the head retires in the same cycle.
  assign Stall          = StoreValid && r_count == CW'(DEPTH) && !w_drain;
  assign w_accept       = StoreValid && !Stall;
  assign MemWriteEnable = w_drain;
  assign MemAddress     = LoadValid ? LoadAddr : r_addr[r_head];
  assign MemWriteData   = r_data[r_head];
  assign Count          = r_count;
  assign Empty          = r_count == '0;
  assign LoadData       = w_hit ? w_fwd : MemReadData;
  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count && r_addr[r_head + PW'(i)][IDX_HI:2] == LoadAddr[IDX_HI:2]) begin
        w_hit = 1'b1;
        w_fwd = r_data[r_head + PW'(i)];
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_addr[r_tail] <= StoreAddr;
        r_data[r_tail] <= StoreData;
        r_tail         <= r_tail + PW'(1);
      end
      if (w_drain) r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_accept) - CW'(w_drain);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer against a queue-based reference model and a data_mem model.
module tb_store_buffer;
  localparam int DEPTH  = 4;
  localparam int IDX_HI = 13;
  localparam int MW     = 1 << (IDX_HI - 1);
  logic        clk = 0, rst_n = 0;
  logic        StoreValid = 0, LoadValid = 0;
  logic [31:0] StoreAddr = 0, StoreData = 0, LoadAddr = 0;
  logic [31:0] LoadData, MemAddress, MemWriteData, MemReadData;
  logic        Stall, MemWriteEnable, Empty;
  logic [2:0]  Count;
  store_buffer #(.DEPTH(DEPTH), .IDX_HI(IDX_HI)) dut (
    .clk(clk), .rst_n(rst_n),
    .StoreValid(StoreValid), .StoreAddr(StoreAddr), .StoreData(StoreData),
    .LoadValid(LoadValid), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .Stall(Stall), .MemWriteEnable(MemWriteEnable), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemReadData(MemReadData),
    .Count(Count), .Empty(Empty)
  );
  always #5 clk = ~clk;
  logic [31:0] dmem    [MW];
  logic [31:0] ref_mem [MW];
  assign MemReadData = dmem[MemAddress[IDX_HI:2]];
  always @(posedge clk) if (MemWriteEnable) dmem[MemAddress[IDX_HI:2]] <= MemWriteData;
  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  typedef struct { int cnt; bit stall; bit mwe; bit ldv; logic [31:0] ld; } exp_t;
  ent_t q[$];
  ent_t exp_wr[$];
  exp_t ecq[$];
  int checks = 0, errors = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask
  function automatic logic [31:0] model_load(logic [31:0] la);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a[IDX_HI:2] == la[IDX_HI:2]) return q[i].d;
    return ref_mem[la[IDX_HI:2]];
  endfunction
  // One cycle: drive inputs, record expected outputs, advance the model, wait for the edge.
  task automatic step(bit sv, logic [31:0] sa, logic [31:0] sd, bit lv, logic [31:0] la, output bit acc);
    exp_t e;
    bit drain;
    StoreValid = sv; StoreAddr = sa; StoreData = sd; LoadValid = lv; LoadAddr = la;
    drain   = !lv && q.size() != 0;
    e.cnt   = q.size();
    e.stall = sv && q.size() == DEPTH && !drain;
    e.mwe   = drain;
    e.ldv   = lv;
    e.ld    = lv ? model_load(la) : 32'h0;
    acc     = sv && !e.stall;
    ecq.push_back(e);
    if (acc) exp_wr.push_back('{sa, sd});
    if (drain) begin
      ref_mem[q[0].a[IDX_HI:2]] = q[0].d;
      void'(q.pop_front());
    end
    if (acc) q.push_back('{sa, sd});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst_n && ecq.size() > 0) begin
      exp_t e;
      e = ecq.pop_front();
      chk("count", 32'(Count), e.cnt);
      chk("empty", 32'(Empty), 32'(e.cnt == 0));
      chk("stall", 32'(Stall), 32'(e.stall));
      chk("mem_we", 32'(MemWriteEnable), 32'(e.mwe));
      if (e.ldv) chk("load_data", LoadData, e.ld);
      if (MemWriteEnable) begin
        if (exp_wr.size() == 0) chk("unexpected_write", MemAddress, 32'hxxxx_xxxx);
        else begin
          ent_t w;
          w = exp_wr.pop_front();
          chk("write_addr", MemAddress, w.a);
          chk("write_data", MemWriteData, w.d);
        end
      end
    end
  end
  function automatic logic [31:0] rnd_addr();
    return ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
  endfunction
  initial begin
    bit acc, pend, lv;
    logic [31:0] sa, sd, la;
    for (int i = 0; i < MW; i++) begin
      dmem[i]    = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
      ref_mem[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(Count), 0);
    chk("reset_empty", 32'(Empty), 1);
    chk("reset_we", 32'(MemWriteEnable), 0);
    chk("reset_stall", 32'(Stall), 0);
    chk("reset_memaddr", MemAddress, 0);
    rst_n = 1;
    // Single store drains, then read back from memory.
    step(1, 32'h10, 32'hDEAD_BEEF, 0, 0, acc);
    step(0, 0, 0, 0, 0, acc);
    step(0, 0, 0, 1, 32'h10, acc);
    chk("drained_value", ref_mem[4], 32'hDEAD_BEEF);
    // Youngest-match forwarding while loads block draining.
    step(1, 32'h20, 1, 1, 32'h40, acc);
    step(1, 32'h20, 2, 1, 32'h40, acc);
    step(1, 32'h24, 3, 1, 32'h40, acc);
    step(0, 0, 0, 1, 32'h20, acc);
    chk("youngest_fwd_model", model_load(32'h20), 2);
    repeat (4) step(0, 0, 0, 0, 0, acc);
    // Full queue: store stalls while load present, enqueues while head drains.
    for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 1, 32'h40, acc);
    step(1, 32'h200, 32'hB5, 1, 32'h40, acc);
    chk("full_stall_model", 32'(acc), 0);
    step(1, 32'h200, 32'hB5, 0, 0, acc);
    chk("full_accept_model", 32'(acc), 1);
    repeat (5) step(0, 0, 0, 0, 0, acc);
    // Wrap-around: ten stores with idle gaps.
    for (int i = 0; i < 10; i++) begin
      step(1, 32'h300 + 32'(i * 4), 32'hC000 + 32'(i), 0, 0, acc);
      if (i % 3 == 0) step(0, 0, 0, 0, 0, acc);
    end
    repeat (6) step(0, 0, 0, 0, 0, acc);
    // Reset mid-operation with three queued stores.
    for (int i = 0; i < 3; i++) step(1, 32'h500 + 32'(i * 4), 32'hE0 + 32'(i), 1, 32'h40, acc);
    rst_n = 0;
    #1;
    chk("midreset_count", 32'(Count), 0);
    chk("midreset_empty", 32'(Empty), 1);
    chk("midreset_we", 32'(MemWriteEnable), 0);
    q.delete();
    exp_wr.delete();
    ecq.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h500 + 32'(i * 4), acc);
    // Randomized traffic; a stalled store is held until accepted.
    pend = 0; sa = 0; sd = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1; sa = rnd_addr(); sd = $urandom();
      end
      lv = $urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 3 : 8);
      la = rnd_addr();
      step(pend, sa, sd, lv, la, acc);
      if (acc) pend = 0;
    end
    for (int c = 0; c < 10; c++) step(0, 0, 0, 0, 0, acc);
    chk("final_pending_writes", 32'(exp_wr.size()), 0);
    chk("final_empty", 32'(Empty), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
